idu_queue: RTL and testbench



---
 rtl/idu_queue_pkg.sv | 44 ++++
 rtl/idu_predecode.sv | 29 ++
 rtl/idu_queue.sv | 121 ++++++++++++
 tb/tb_idu_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_queue_pkg.sv
// Shared definitions for the decode-side instruction queue: predecode flag
// layout, RV32I major opcodes and the exact SYSTEM encodings we recognise.
package idu_queue_pkg;

  // Predecode flag vector width and bit positions, bit 8 down to bit 0:
  // {illegal, mret, ecall, sys, store, load, jalr, jal, brch}.
  localparam int PDC_W       = 9;
  localparam int PDC_BRCH    = 0;
  localparam int PDC_JAL     = 1;
  localparam int PDC_JALR    = 2;
  localparam int PDC_LOAD    = 3;
  localparam int PDC_STORE   = 4;
  localparam int PDC_SYS     = 5;
  localparam int PDC_ECALL   = 6;
  localparam int PDC_MRET    = 7;
  localparam int PDC_ILLEGAL = 8;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] TYPE_SYS     = 7'b1110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // Full-word encodings of the two SYSTEM instructions flagged individually.
  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
  localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;

  // True for every major opcode the core implements; anything else is illegal.
  function automatic logic is_known_opcode(input logic [6:0] opc);
    case (opc)
      OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, TYPE_SYS,
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/idu_predecode.sv
// Combinational opcode-class predecoder. Classifies one instruction word so
// the flags can be stored alongside it and handed to the decoder together.
module idu_predecode
  import idu_queue_pkg::*;
(
  input  logic [31:0]      i_instr,
  output logic [PDC_W-1:0] o_pdc
);

  logic [6:0] opc;
  assign opc = i_instr[6:0];

  // Derive each class flag from the major opcode or the exact encoding.
  always_comb begin
    // NOTE: a full default before any partial assignment keeps this block
    // purely combinational; a missed bit would otherwise infer a latch.
    o_pdc                = '0;
    o_pdc[PDC_BRCH]      = (opc == OPC_BRANCH);
    o_pdc[PDC_JAL]       = (opc == OPC_JAL);
    o_pdc[PDC_JALR]      = (opc == OPC_JALR);
    o_pdc[PDC_LOAD]      = (opc == OPC_LOAD);
    o_pdc[PDC_STORE]     = (opc == OPC_STORE);
    o_pdc[PDC_SYS]       = (opc == TYPE_SYS);
    o_pdc[PDC_ECALL]     = (i_instr == INSTR_ECALL);
    o_pdc[PDC_MRET]      = (i_instr == INSTR_MRET);
    o_pdc[PDC_ILLEGAL]   = !is_known_opcode(opc);
  end

endmodule

// File: rtl/idu_queue.sv
// Decode-side instruction queue between IFU and decoder. Holds up to DEPTH
// {instr, pc, predecode} entries, optionally forwards straight through when
// empty, and drops everything in one cycle on a redirect flush.
module idu_queue
  import idu_queue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_pre_valid,
  output logic                     o_pre_ready,
  input  logic [31:0]              i_instr,
  input  logic [XLEN-1:0]          i_pc,
  input  logic                     i_flush,
  output logic                     o_post_valid,
  input  logic                     i_post_ready,
  output logic [31:0]              o_instr,
  output logic [XLEN-1:0]          o_pc,
  output logic [PDC_W-1:0]         o_pdc,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam bit BYP = (BYPASS != 0);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  logic [31:0]      mem_instr_q [DEPTH];
  logic [XLEN-1:0]  mem_pc_q    [DEPTH];
  logic [PDC_W-1:0] mem_pdc_q   [DEPTH];

  logic [PDC_W-1:0] in_pdc;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             empty, full;
  logic             bypass_taken, push, pop;

  idu_predecode u_predecode (
    .i_instr (i_instr),
    .o_pdc   (in_pdc)
  );

  // Occupancy flags and the handshake decisions for this cycle.
  always_comb begin
    wr_idx       = wr_ptr_q[AW-1:0];
    rd_idx       = rd_ptr_q[AW-1:0];
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    // An empty queue with a ready consumer hands the input straight over.
    bypass_taken = BYP && empty && i_pre_valid && i_post_ready && !i_flush;
    // Ready depends on occupancy alone, never on i_post_ready.
    o_pre_ready  = !full;
    if (BYP && empty) begin
      o_post_valid = i_pre_valid && !i_flush;
    end else begin
      o_post_valid = !empty && !i_flush;
    end
    push         = i_pre_valid && o_pre_ready && !i_flush && !bypass_taken;
    pop          = o_post_valid && i_post_ready && !bypass_taken;
    o_count      = wr_ptr_q - rd_ptr_q;
  end

  // Next-pointer computation; flush returns both pointers to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage: write the incoming pair and its predecode on push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: the entry array is reset on purpose so the head outputs read as
    // zero out of reset; it is small enough to live in plain flops.
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
        mem_pdc_q[i]   <= '0;
      end
    end else if (push) begin
      mem_instr_q[wr_idx] <= i_instr;
      mem_pc_q[wr_idx]    <= i_pc;
      mem_pdc_q[wr_idx]   <= in_pdc;
    end
  end

  // Head payload: input path while bypassing an empty queue, else the entry.
  always_comb begin
    if (BYP && empty) begin
      o_instr = i_instr;
      o_pc    = i_pc;
      o_pdc   = in_pdc;
    end else begin
      o_instr = mem_instr_q[rd_idx];
      o_pc    = mem_pc_q[rd_idx];
      o_pdc   = mem_pdc_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_idu_queue.sv
// Bench for idu_queue: one registered-only instance (BYPASS=0) and one
// bypassing instance (BYPASS=1), driven with identical inputs. A queue-based
// reference model checks both every cycle; a vector table and short
// sequences add hand-computed expectations.
module tb_idu_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv, fl, pr;
  logic [31:0] instr, pc;

  logic        o0_rdy, o0_v, o1_rdy, o1_v;
  logic [31:0] o0_i, o0_p, o1_i, o1_p;
  logic [8:0]  o0_d, o1_d;
  logic [2:0]  o0_c, o1_c;

  int total = 0;
  int bad   = 0;

  logic [63:0] mq0[$];
  logic [63:0] mq1[$];

  always #5 clk = ~clk;

  idu_queue #(.XLEN(32), .DEPTH(DEPTH), .BYPASS(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pre_valid(pv), .o_pre_ready(o0_rdy),
    .i_instr(instr), .i_pc(pc), .i_flush(fl), .o_post_valid(o0_v),
    .i_post_ready(pr), .o_instr(o0_i), .o_pc(o0_p), .o_pdc(o0_d), .o_count(o0_c)
  );

  idu_queue #(.XLEN(32), .DEPTH(DEPTH), .BYPASS(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pre_valid(pv), .o_pre_ready(o1_rdy),
    .i_instr(instr), .i_pc(pc), .i_flush(fl), .o_post_valid(o1_v),
    .i_post_ready(pr), .o_instr(o1_i), .o_pc(o1_p), .o_pdc(o1_d), .o_count(o1_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flag vector written straight from the opcode classification rules.
  function automatic logic [8:0] ref_pdc(input logic [31:0] w);
    logic [8:0] d;
    d = 9'h000;
    case (w[6:0])
      7'b1100011: d = 9'h001;
      7'b1101111: d = 9'h002;
      7'b1100111: d = 9'h004;
      7'b0000011: d = 9'h008;
      7'b0100011: d = 9'h010;
      7'b1110011: d = 9'h020;
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b0001111: d = 9'h000;
      default:    d = 9'h100;
    endcase
    if (w == 32'h0000_0073) d = d | 9'h040;
    if (w == 32'h3020_0073) d = d | 9'h080;
    return d;
  endfunction

  // Compare one instance's outputs against the model for the current inputs.
  task automatic model_cmp(input string tag, input bit byp, input int sz, input logic [63:0] head,
                           input logic a_v, input logic a_r, input logic [2:0] a_c,
                           input logic [31:0] a_i, input logic [31:0] a_p, input logic [8:0] a_d);
    logic        ev;
    logic [31:0] ei, ep;
    if (byp && sz == 0) begin
      ev = pv && !fl; ei = instr; ep = pc;
    end else begin
      ev = (sz != 0) && !fl; ei = head[63:32]; ep = head[31:0];
    end
    check({tag, " valid"}, 64'(a_v), 64'(ev));
    check({tag, " ready"}, 64'(a_r), 64'(sz < DEPTH));
    check({tag, " count"}, 64'(a_c), 64'(sz));
    if (ev) begin
      check({tag, " instr"}, 64'(a_i), 64'(ei));
      check({tag, " pc"},    64'(a_p), 64'(ep));
      check({tag, " pdc"},   64'(a_d), 64'(ref_pdc(ei)));
    end
  endtask

  // Returns {push, pop} the model expects for a queue of size sz.
  function automatic logic [1:0] decide(input bit byp, input int sz);
    logic bt, ev;
    bt = byp && sz == 0 && pv && pr;
    ev = (byp && sz == 0) ? pv : (sz != 0);
    return {pv && (sz < DEPTH) && !bt, ev && pr && !bt};
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                       input logic f, input logic r);
    @(negedge clk);
    pv = v; instr = w; pc = p; fl = f; pr = r;
    #1;
    model_cmp("m0", 1'b0, mq0.size(), (mq0.size() != 0) ? mq0[0] : 64'h0,
              o0_v, o0_rdy, o0_c, o0_i, o0_p, o0_d);
    model_cmp("m1", 1'b1, mq1.size(), (mq1.size() != 0) ? mq1[0] : 64'h0,
              o1_v, o1_rdy, o1_c, o1_i, o1_p, o1_d);
  endtask

  task automatic tick();
    logic [1:0] d0, d1;
    @(posedge clk);
    if (fl) begin
      mq0.delete();
      mq1.delete();
    end else begin
      d0 = decide(1'b0, mq0.size());
      d1 = decide(1'b1, mq1.size());
      if (d0[0]) void'(mq0.pop_front());
      if (d0[1]) mq0.push_back({instr, pc});
      if (d1[0]) void'(mq1.pop_front());
      if (d1[1]) mq1.push_back({instr, pc});
    end
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fl;
    logic        pr;
    logic        ev;
    logic        er;
    logic [2:0]  ec;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [8:0]  ed;
  } vec_t;

  function automatic vec_t row(input logic v, input logic [31:0] w, input logic [31:0] p,
                               input logic f, input logic r, input logic ev, input logic er,
                               input logic [2:0] ec, input logic [31:0] ei, input logic [31:0] ep,
                               input logic [8:0] ed);
    vec_t t;
    t.pv = v; t.instr = w; t.pc = p; t.fl = f; t.pr = r;
    t.ev = ev; t.er = er; t.ec = ec; t.ei = ei; t.ep = ep; t.ed = ed;
    return t;
  endfunction

  vec_t tbl [20];

  initial begin
    // Expected values for the BYPASS=0 instance, observed before each edge.
    tbl[0]  = row(1, 32'h0000_0013, 32'h8000_0000, 0, 0,  0, 1, 0, 0, 0, 9'h000);
    tbl[1]  = row(0, 32'h0,         32'h0,         0, 0,  1, 1, 1, 32'h0000_0013, 32'h8000_0000, 9'h000);
    tbl[2]  = row(1, 32'h3020_0073, 32'h8000_0004, 0, 0,  1, 1, 1, 32'h0000_0013, 32'h8000_0000, 9'h000);
    tbl[3]  = row(1, 32'h0000_006F, 32'h8000_0008, 0, 0,  1, 1, 2, 32'h0000_0013, 32'h8000_0000, 9'h000);
    tbl[4]  = row(1, 32'hFFFF_FFFF, 32'h8000_000C, 0, 0,  1, 1, 3, 32'h0000_0013, 32'h8000_0000, 9'h000);
    tbl[5]  = row(1, 32'h0000_0073, 32'h8000_0010, 0, 0,  1, 0, 4, 32'h0000_0013, 32'h8000_0000, 9'h000);
    tbl[6]  = row(1, 32'h0000_0073, 32'h8000_0010, 0, 1,  1, 0, 4, 32'h0000_0013, 32'h8000_0000, 9'h000);
    tbl[7]  = row(1, 32'h0000_0073, 32'h8000_0010, 0, 0,  1, 1, 3, 32'h3020_0073, 32'h8000_0004, 9'h0A0);
    tbl[8]  = row(0, 32'h0,         32'h0,         0, 1,  1, 0, 4, 32'h3020_0073, 32'h8000_0004, 9'h0A0);
    tbl[9]  = row(0, 32'h0,         32'h0,         0, 1,  1, 1, 3, 32'h0000_006F, 32'h8000_0008, 9'h002);
    tbl[10] = row(0, 32'h0,         32'h0,         0, 1,  1, 1, 2, 32'hFFFF_FFFF, 32'h8000_000C, 9'h100);
    tbl[11] = row(0, 32'h0,         32'h0,         0, 1,  1, 1, 1, 32'h0000_0073, 32'h8000_0010, 9'h060);
    tbl[12] = row(0, 32'h0,         32'h0,         0, 0,  0, 1, 0, 0, 0, 9'h000);
    tbl[13] = row(1, 32'h0000_0003, 32'h9000_0000, 0, 0,  0, 1, 0, 0, 0, 9'h000);
    tbl[14] = row(1, 32'h0000_0023, 32'h9000_0004, 0, 0,  1, 1, 1, 32'h0000_0003, 32'h9000_0000, 9'h008);
    tbl[15] = row(1, 32'h0000_0063, 32'h9000_0008, 0, 0,  1, 1, 2, 32'h0000_0003, 32'h9000_0000, 9'h008);
    tbl[16] = row(1, 32'h0000_0067, 32'h9000_000C, 1, 1,  0, 1, 3, 0, 0, 9'h000);
    tbl[17] = row(1, 32'h0000_0037, 32'hA000_0000, 0, 0,  0, 1, 0, 0, 0, 9'h000);
    tbl[18] = row(0, 32'h0,         32'h0,         0, 1,  1, 1, 1, 32'h0000_0037, 32'hA000_0000, 9'h000);
    tbl[19] = row(0, 32'h0,         32'h0,         0, 0,  0, 1, 0, 0, 0, 9'h000);

    // Reset state.
    rst_n = 1'b0; pv = 0; fl = 0; pr = 0; instr = '0; pc = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst valid0", 64'(o0_v),   64'h0);
    check("rst count0", 64'(o0_c),   64'h0);
    check("rst ready0", 64'(o0_rdy), 64'h1);
    check("rst instr0", 64'(o0_i),   64'h0);
    check("rst pc0",    64'(o0_p),   64'h0);
    check("rst pdc0",   64'(o0_d),   64'h0);
    check("rst valid1", 64'(o1_v),   64'h0);
    check("rst count1", 64'(o1_c),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table: fill, full, pop-while-full, decode, flush.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].pv, tbl[i].instr, tbl[i].pc, tbl[i].fl, tbl[i].pr);
      check($sformatf("tbl%0d valid", i), 64'(o0_v),   64'(tbl[i].ev));
      check($sformatf("tbl%0d ready", i), 64'(o0_rdy), 64'(tbl[i].er));
      check($sformatf("tbl%0d count", i), 64'(o0_c),   64'(tbl[i].ec));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d instr", i), 64'(o0_i), 64'(tbl[i].ei));
        check($sformatf("tbl%0d pc", i),    64'(o0_p), 64'(tbl[i].ep));
        check($sformatf("tbl%0d pdc", i),   64'(o0_d), 64'(tbl[i].ed));
      end
      tick();
    end

    // Zero-latency bypass of an ecall through the empty BYPASS=1 queue.
    drive(1, 32'h0000_0073, 32'h8000_1000, 0, 1);
    check("byp valid", 64'(o1_v), 64'h1);
    check("byp instr", 64'(o1_i), 64'h73);
    check("byp pdc",   64'(o1_d), 64'h060);
    check("nobyp valid", 64'(o0_v), 64'h0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    check("byp count after", 64'(o1_c), 64'h0);
    check("nobyp count after", 64'(o0_c), 64'h1);
    tick();
    drive(0, 32'h0, 32'h0, 0, 1);
    tick();

    // Sustained push+pop across pointer wrap: in-order PCs, constant count.
    drive(1, 32'h0000_0013, 32'hC000_0000, 0, 0); tick();
    drive(1, 32'h0000_0013, 32'hC000_0004, 0, 0); tick();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h0000_0013, 32'hC000_0000 + 32'(4 * (k + 2)), 0, 1);
      check($sformatf("wrap%0d pc0", k),    64'(o0_p), 64'(32'hC000_0000 + 32'(4 * k)));
      check($sformatf("wrap%0d pc1", k),    64'(o1_p), 64'(32'hC000_0000 + 32'(4 * k)));
      check($sformatf("wrap%0d count0", k), 64'(o0_c), 64'h2);
      check($sformatf("wrap%0d count1", k), 64'(o1_c), 64'h2);
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 1); tick();

    // Randomised traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] w;
      case ($urandom % 8)
        0: w = 32'h0000_0073;
        1: w = 32'h3020_0073;
        2: w = 32'h0000_006F;
        3: w = 32'hFFFF_FFFF;
        default: w = $urandom;
      endcase
      drive(($urandom % 4) != 0, w, $urandom, ($urandom % 16) == 0, ($urandom % 3) != 0);
      tick();
    end

    // Reset asserted mid-operation clears everything immediately.
    drive(1, 32'h0000_0013, 32'hD000_0000, 0, 0); tick();
    drive(1, 32'h0000_0013, 32'hD000_0004, 0, 0); tick();
    @(negedge clk);
    pv = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst count0", 64'(o0_c),   64'h0);
    check("mid rst valid0", 64'(o0_v),   64'h0);
    check("mid rst ready0", 64'(o0_rdy), 64'h1);
    check("mid rst count1", 64'(o1_c),   64'h0);
    mq0.delete();
    mq1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
